// File: rtl/cache_arb_pkg.sv
// Shared definitions for the two-core cache request arbiter.
// Request layout: {pid, ld/st, tag[10:0], offset, data[7:0]}.
package cache_arb_pkg;

  localparam int REQ_W     = 22;
  localparam int PID_BIT   = 21;
  localparam int LS_BIT    = 20;
  localparam int TAG_MSB   = 19;
  localparam int TAG_LSB   = 9;
  localparam int OFF_BIT   = 8;
  localparam int DATA_MSB  = 7;
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                     pid;
    logic                     ls;
    logic [TAG_MSB-TAG_LSB:0] tag;
    logic                     off;
    logic [DATA_MSB:0]        data;
  } cache_req_t;

  // Replace the requester id field with the port that actually sent it.
  function automatic logic [REQ_W-1:0] stamp_pid(input logic [REQ_W-1:0] r,
                                                 input logic pid);
    logic [REQ_W-1:0] s;
    s          = r;
    s[PID_BIT] = pid;
    return s;
  endfunction

endpackage

// File: rtl/cache_req_fifo.sv
// Synchronous first-word-fall-through FIFO, one per core port.
// Ports:
//   clk, reset    rising-edge clock, async active-high reset (flushes)
//   push, din     write strobe / data; ignored while full
//   pop           read strobe; ignored while empty
//   dout          head entry (valid when !empty)
//   count         occupancy, 0..DEPTH
//   empty         no entries
module cache_req_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  // Full comes from the registered count, so a push into a full FIFO is
  // refused even when the same edge pops.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Two-core front end for the shared cache: per-core request FIFOs, round-robin
// grant, single outstanding request, response routed back by pid bit.
// Optional build macro: CACHE_ARB_TIMEOUT_EN enables the WAIT_RESP watchdog
// (TIMEOUT_CYCLES); without it arb_timeout is tied low.
// Ports:
//   clk, reset                   clock, async active-high reset
//   pX_req_valid/pX_req          core X request strobe / payload
//   pX_req_ready                 core X FIFO has room
//   cache_req_valid/cache_req    request to the cache, held until accepted
//   cache_busy                   cache cannot accept this cycle
//   cache_resp_valid/cache_resp  cache response, bit 21 = owning core
//   pX_resp_valid                one-cycle pulse, resp_data belongs to core X
//   resp_data                    registered response payload
//   arb_timeout                  one-cycle watchdog expiry pulse
module cache_req_arbiter
  import cache_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
`ifdef CACHE_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p0_req_valid,
  input  logic [REQ_W-1:0] p0_req,
  output logic             p0_req_ready,
  input  logic             p1_req_valid,
  input  logic [REQ_W-1:0] p1_req,
  output logic             p1_req_ready,
  output logic             cache_req_valid,
  output logic [REQ_W-1:0] cache_req,
  input  logic             cache_busy,
  input  logic             cache_resp_valid,
  input  logic [REQ_W-1:0] cache_resp,
  output logic             p0_resp_valid,
  output logic             p1_resp_valid,
  output logic [REQ_W-1:0] resp_data,
  output logic             arb_timeout
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_PORTS-1:0]            req_valid, req_ready, fifo_pop, fifo_empty;
  logic [NUM_PORTS-1:0][REQ_W-1:0] req_in, fifo_dout;

  assign req_valid    = {p1_req_valid, p0_req_valid};
  assign req_in[0]    = p0_req;
  assign req_in[1]    = p1_req;
  assign p0_req_ready = req_ready[0];
  assign p1_req_ready = req_ready[1];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [CW-1:0] count;

    cache_req_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (req_valid[i]),
      .din   (stamp_pid(req_in[i], (i == 1))),
      .pop   (fifo_pop[i]),
      .dout  (fifo_dout[i]),
      .count (count),
      .empty (fifo_empty[i])
    );

    assign req_ready[i] = (count < CW'(FIFO_DEPTH));
  end

  arb_state_e       state, state_nxt;
  logic             last_grant, last_grant_nxt, sel;
  cache_req_t       req_q, req_nxt;
  logic             req_valid_nxt;
  logic [REQ_W-1:0] resp_nxt;
  logic             p0_rv_nxt, p1_rv_nxt;
  logic             resp_fire;

  assign cache_req = req_q;

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit, tmo_nxt;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  assign resp_fire = (state == WAIT_RESP) & cache_resp_valid;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    req_nxt        = req_q;
    req_valid_nxt  = cache_req_valid;
    resp_nxt       = resp_data;
    p0_rv_nxt      = 1'b0;
    p1_rv_nxt      = 1'b0;
    fifo_pop       = '0;
    sel            = 1'b0;
`ifdef CACHE_ARB_TIMEOUT_EN
    tmo_nxt        = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (~&fifo_empty) begin
          // Both waiting: alternate away from the last winner; otherwise take
          // whichever port has data.
          sel            = ~|fifo_empty ? ~last_grant : fifo_empty[0];
          fifo_pop[sel]  = 1'b1;
          req_nxt        = fifo_dout[sel];
          req_valid_nxt  = 1'b1;
          last_grant_nxt = sel;
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        if (!cache_busy) begin
          req_valid_nxt = 1'b0;
          state_nxt     = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (resp_fire) begin
          resp_nxt  = cache_resp;
          p0_rv_nxt = ~cache_resp[PID_BIT];
          p1_rv_nxt = cache_resp[PID_BIT];
          state_nxt = IDLE;
        end
`ifdef CACHE_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          tmo_nxt   = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      req_q           <= '0;
      cache_req_valid <= 1'b0;
      resp_data       <= '0;
      p0_resp_valid   <= 1'b0;
      p1_resp_valid   <= 1'b0;
    end else begin
      state           <= state_nxt;
      last_grant      <= last_grant_nxt;
      req_q           <= req_nxt;
      cache_req_valid <= req_valid_nxt;
      resp_data       <= resp_nxt;
      p0_resp_valid   <= p0_rv_nxt;
      p1_resp_valid   <= p1_rv_nxt;
    end
  end

`ifdef CACHE_ARB_TIMEOUT_EN
  // Cleared on the accepting edge, so it reads 0 on the first WAIT_RESP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      arb_timeout <= 1'b0;
    end else begin
      arb_timeout <= tmo_nxt;
      if (state == ISSUE && !cache_busy) tmo_cnt <= '0;
      else if (state == WAIT_RESP)       tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
module tb_cache_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req_valid, p1_req_valid, p0_req_ready, p1_req_ready;
  logic [21:0] p0_req, p1_req, cache_req, cache_resp, resp_data;
  logic        cache_req_valid, cache_busy, cache_resp_valid;
  logic        p0_resp_valid, p1_resp_valid, arb_timeout;

  int total = 0;
  int bad   = 0;

  logic [21:0] exp_req_q[$];
  logic [22:0] exp_resp_q[$];
  int          tmo_exp = 0;
  logic [21:0] last_rsp = '0;
  logic        prev_vb = 1'b0;
  logic [21:0] prev_req = '0;

  always #5 clk = ~clk;

  cache_req_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req(p0_req), .p0_req_ready(p0_req_ready),
    .p1_req_valid(p1_req_valid), .p1_req(p1_req), .p1_req_ready(p1_req_ready),
    .cache_req_valid(cache_req_valid), .cache_req(cache_req), .cache_busy(cache_busy),
    .cache_resp_valid(cache_resp_valid), .cache_resp(cache_resp),
    .p0_resp_valid(p0_resp_valid), .p1_resp_valid(p1_resp_valid),
    .resp_data(resp_data), .arb_timeout(arb_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic v0, input logic [21:0] d0,
                       input logic v1, input logic [21:0] d1);
    p0_req_valid = v0; p0_req = d0;
    p1_req_valid = v1; p1_req = d1;
    tick();
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
  endtask

  // Acts as the cache: wait for a request, stay busy busy_n edges, accept,
  // then optionally answer after delay cycles.
  task automatic serve(input int busy_n, input logic [21:0] rsp,
                       input logic give_rsp, input int delay);
    for (int i = 0; i < 200 && !cache_req_valid; i++) tick();
    if (!cache_req_valid) begin
      total++; bad++;
      $display("FAIL serve_wait: cache_req_valid never rose, want 1");
      return;
    end
    repeat (busy_n) tick();
    cache_busy = 1'b0;
    tick();
    cache_busy = 1'b1;
    if (give_rsp) begin
      repeat (delay) tick();
      cache_resp       = rsp;
      cache_resp_valid = 1'b1;
      exp_resp_q.push_back({rsp[21], rsp});
      last_rsp = rsp;
      tick();
      cache_resp_valid = 1'b0;
    end
  endtask

  // Monitor: inputs change just after posedge, so at negedge both the inputs
  // for the coming edge and the registered outputs are settled.
  always @(negedge clk) begin
    if (reset) begin
      prev_vb = 1'b0;
    end else begin
      if (cache_req_valid && prev_vb) begin
        total++;
        if (cache_req !== prev_req) begin
          bad++;
          $display("FAIL busy_hold: got %0h want %0h", cache_req, prev_req);
        end
      end
      if (cache_req_valid && !cache_busy) begin
        total++;
        if (exp_req_q.size() == 0) begin
          bad++;
          $display("FAIL issue_unexp: got %0h want none", cache_req);
        end else begin
          logic [21:0] e;
          e = exp_req_q.pop_front();
          if (cache_req !== e) begin
            bad++;
            $display("FAIL issue: got %0h want %0h", cache_req, e);
          end
        end
      end
      prev_vb  = cache_req_valid && cache_busy;
      prev_req = cache_req;
      if (p0_resp_valid || p1_resp_valid) begin
        total++;
        if (p0_resp_valid && p1_resp_valid) begin
          bad++;
          $display("FAIL resp_both: got p0=1 p1=1 want one");
        end else if (exp_resp_q.size() == 0) begin
          bad++;
          $display("FAIL resp_unexp: got port%0d %0h want none", p1_resp_valid, resp_data);
        end else begin
          logic [22:0] e;
          e = exp_resp_q.pop_front();
          if ({p1_resp_valid, resp_data} !== e) begin
            bad++;
            $display("FAIL resp: got port%0d %0h want port%0d %0h",
                     p1_resp_valid, resp_data, e[22], e[21:0]);
          end
        end
      end
      if (arb_timeout) begin
        total++;
        if (tmo_exp == 0) begin
          bad++;
          $display("FAIL tmo_unexp: got 1 want 0");
        end else tmo_exp--;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: sim still running, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] a0, a1, s, b0, b1, c1, t, r0, r1, n;
    logic [21:0] d [5];
    int found;

    reset = 1'b1;
    p0_req_valid = 1'b0; p1_req_valid = 1'b0; p0_req = '0; p1_req = '0;
    cache_busy = 1'b1; cache_resp_valid = 1'b0; cache_resp = '0;
    tick(); tick();
    chk("rst_cvalid", 32'(cache_req_valid), 32'd0);
    chk("rst_creq",   32'(cache_req),       32'd0);
    chk("rst_rdata",  32'(resp_data),       32'd0);
    chk("rst_rv",     32'({p0_resp_valid, p1_resp_valid, arb_timeout}), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_ready",  32'({p0_req_ready, p1_req_ready}), 32'd3);

    // Contention out of reset: p0 wins first.
    a0 = 22'b0_1_01010000000_1_00000000;
    a1 = 22'b1_0_01010000000_1_11111111;
    exp_req_q.push_back(a0);
    exp_req_q.push_back(a1);
    push2(1'b1, a0, 1'b1, a1);
    serve(0, {a0[21:8], 8'h11}, 1'b1, 1);
    serve(0, {a1[21:8], 8'h22}, 1'b1, 0);

    // Single load with latency check.
    s = 22'b0_0_01011010000_0_00000000;
    exp_req_q.push_back(s);
    push2(1'b1, s, 1'b0, '0);
    chk("lat_k",    32'(cache_req_valid), 32'd0);
    tick();
    chk("lat_k1",   32'(cache_req_valid), 32'd1);
    chk("lat_data", 32'(cache_req),       32'(s));
    serve(0, 22'b0_0_01011010000_0_10101010, 1'b1, 2);

    // Last winner was p0, so this pair goes p1 first; p1's request is held busy.
    b0 = 22'b0_0_00000000111_0_01000001;
    b1 = 22'b0_1_00000001110_1_01000010;
    exp_req_q.push_back({1'b1, b1[20:0]});
    exp_req_q.push_back(b0);
    push2(1'b1, b0, 1'b1, b1);
    serve(3, {1'b1, b1[20:8], 8'h33}, 1'b1, 0);
    serve(0, {b0[21:8], 8'h44}, 1'b1, 3);

    // PID stamp, then fill p0 while p1's request stalls in ISSUE.
    c1 = 22'b0_1_00000000011_1_00110011;
    exp_req_q.push_back({1'b1, c1[20:0]});
    push2(1'b0, '0, 1'b1, c1);
    for (int i = 0; i < 5; i++) begin
      d[i] = {2'b00, 11'(i + 1), 1'b0, 8'(208 + i)};
      p0_req_valid = 1'b1;
      p0_req       = d[i];
      if (i < 4) exp_req_q.push_back(d[i]);
      tick();
      if (i == 2) chk("ready_3", 32'(p0_req_ready), 32'd1);
      if (i == 3) chk("full_ready", 32'(p0_req_ready), 32'd0);
    end
    p0_req_valid = 1'b0;
    chk("pid_stamp", 32'(cache_req[21]), 32'd1);
    serve(0, {1'b1, c1[20:8], 8'h55}, 1'b1, 0);
    for (int i = 0; i < 4; i++) serve(0, {d[i][21:8], 8'(96 + i)}, 1'b1, 0);
    repeat (3) tick();
    chk("drained",     32'(cache_req_valid), 32'd0);
    chk("ready_again", 32'(p0_req_ready),    32'd1);

    // Unanswered request.
    t = 22'b0_0_00000011111_0_00000001;
    exp_req_q.push_back(t);
    push2(1'b1, t, 1'b0, '0);
    serve(0, '0, 1'b0, 0);
`ifdef CACHE_ARB_TIMEOUT_EN
    tmo_exp = 1;
    found = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (arb_timeout) begin found = i; break; end
    end
    chk("tmo_cycle", 32'(found), 32'd16);
    tick();
    chk("tmo_pulse", 32'(arb_timeout), 32'd0);
`else
    found = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (arb_timeout || p0_resp_valid) found = i;
    end
    chk("no_tmo", 32'(found), 32'd0);
    cache_resp       = {t[21:8], 8'h77};
    cache_resp_valid = 1'b1;
    exp_resp_q.push_back({1'b0, t[21:8], 8'h77});
    last_rsp = {t[21:8], 8'h77};
    tick();
    cache_resp_valid = 1'b0;
`endif
    // Stray response while IDLE: no pulse, resp_data unchanged.
    repeat (2) tick();
    cache_resp       = 22'h3F00AA;
    cache_resp_valid = 1'b1;
    tick();
    cache_resp_valid = 1'b0;
    repeat (3) tick();
    chk("stray_rdata", 32'(resp_data), 32'(last_rsp));

    // Reset mid-operation: one request stalled in ISSUE, one queued.
    r0 = 22'b0_1_00000000001_0_00010001;
    r1 = 22'b0_1_00000000010_0_00010010;
    push2(1'b1, r0, 1'b0, '0);
    push2(1'b1, r1, 1'b0, '0);
    chk("mr_pre", 32'(cache_req_valid), 32'd1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("mr_cvalid", 32'(cache_req_valid), 32'd0);
    chk("mr_creq",   32'(cache_req),       32'd0);
    chk("mr_rdata",  32'(resp_data),       32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("mr_ready", 32'({p0_req_ready, p1_req_ready}), 32'd3);
    n = 22'b0_0_00000000100_1_10011001;
    exp_req_q.push_back(n);
    push2(1'b1, n, 1'b0, '0);
    serve(0, {n[21:8], 8'h88}, 1'b1, 0);
    repeat (5) tick();

    chk("req_q_empty",  32'(exp_req_q.size()),  32'd0);
    chk("resp_q_empty", 32'(exp_resp_q.size()), 32'd0);
    chk("tmo_consumed", 32'(tmo_exp),           32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
